// File: rtl/frame_gen_pkg.sv
// Shared types and constants for the light-cube animation frame generator.
// The LFSR step function lives here so the generator can look one step ahead.
package frame_gen_pkg;

  typedef enum logic [1:0] {
    MODE_ROW     = 2'd0,
    MODE_PLANE   = 2'd1,
    MODE_COLUMN  = 2'd2,
    MODE_SPARKLE = 2'd3
  } mode_e;

  // Galois tap mask for x^32 + x^22 + x^2 + x + 1, right-shifting form.
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR that advances one position whenever step is high.
// A nonzero SEED keeps the sequence out of the all-zero lock-up state.
module lfsr32
  import frame_gen_pkg::*;
#(
  parameter logic [31:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [31:0] state
);

  logic [31:0] state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
    end else if (step) begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign state = state_q;

endmodule

// File: rtl/anim_frame_gen.sv
// Multi-mode animation frame generator for an N x N x N light cube, paced by a prescaled tick.
// Optional FRAME_GEN_OVERRUN_CNT_EN adds a saturating count of ticks dropped under backpressure.
module anim_frame_gen
  import frame_gen_pkg::*;
#(
  parameter int CUBE_N  = 8,
  parameter int CLK_DIV = 23,
  parameter int SPEED_W = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic [SPEED_W-1:0]                display_speed,
  input  logic [1:0]                        mode,
  input  logic                              frame_ready,
  output logic [CUBE_N*CUBE_N*CUBE_N-1:0]   frame_cube_flat,
  output logic                              frame_valid
`ifdef FRAME_GEN_OVERRUN_CNT_EN
  ,
  output logic [7:0]                        overrun_cnt
`endif
);

  localparam int FRAME_W = CUBE_N * CUBE_N * CUBE_N;
  localparam int STEP_W  = $clog2(CUBE_N * CUBE_N);

  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [CLK_DIV-1:0] div_q, div_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               dir_down_q, dir_down_d;
  mode_e              cur_mode_q;
  mode_e              mode_in;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               valid_q, valid_d;
  logic [31:0]        lfsr_q, lfsr_d;
  logic               speed_wrap, tick, accept;

  assign mode_in    = mode_e'(mode);
  assign speed_wrap = (speed_q == display_speed);
  assign tick       = en && speed_wrap && (div_q == '1);
  // A tick is taken when the output slot is free or being emptied this cycle.
  assign accept     = tick && (!valid_q || frame_ready);

  always_comb begin
    speed_d = '0;
    div_d   = '0;
    if (en) begin
      speed_d = speed_wrap ? '0 : speed_q + 1'b1;
      div_d   = speed_wrap ? div_q + 1'b1 : div_q;
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (!en) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (valid_q && frame_ready) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    step_d     = step_q;
    dir_down_d = dir_down_q;
    if (mode_in != cur_mode_q) begin
      step_d     = '0;
      dir_down_d = 1'b0;
    end else begin
      case (cur_mode_q)
        MODE_ROW: begin
          step_d = (step_q == STEP_W'(CUBE_N * CUBE_N - 1)) ? '0 : step_q + 1'b1;
        end
        MODE_PLANE: begin
          // Turn around at each end so neither end layer is shown twice in a row.
          if (!dir_down_q) begin
            if (step_q == STEP_W'(CUBE_N - 1)) begin
              step_d     = STEP_W'(CUBE_N - 2);
              dir_down_d = 1'b1;
            end else begin
              step_d = step_q + 1'b1;
            end
          end else begin
            if (step_q == '0) begin
              step_d     = STEP_W'(1);
              dir_down_d = 1'b0;
            end else begin
              step_d = step_q - 1'b1;
            end
          end
        end
        MODE_COLUMN: begin
          step_d = (step_q == STEP_W'(CUBE_N - 1)) ? '0 : step_q + 1'b1;
        end
        default: step_d = step_q;
      endcase
    end
  end

  // Frame is decoded from the post-tick state, the same values being registered.
  assign lfsr_d = lfsr_next(lfsr_q);

  for (genvar g = 0; g < FRAME_W; g++) begin : g_bit
    assign frame_d[g] =
      (mode_in == MODE_ROW)    ? (step_d == STEP_W'(g / CUBE_N)) :
      (mode_in == MODE_PLANE)  ? (step_d == STEP_W'(g / (CUBE_N * CUBE_N))) :
      (mode_in == MODE_COLUMN) ? (step_d == STEP_W'(g % CUBE_N)) :
                                 (lfsr_d[g % 32] & lfsr_d[(g + 7) % 32]);
  end

  lfsr32 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (accept),
    .state (lfsr_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      speed_q    <= '0;
      div_q      <= '0;
      step_q     <= '0;
      dir_down_q <= 1'b0;
      cur_mode_q <= MODE_ROW;
      frame_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      speed_q <= speed_d;
      div_q   <= div_d;
      valid_q <= valid_d;
      if (accept) begin
        cur_mode_q <= mode_in;
        step_q     <= step_d;
        dir_down_q <= dir_down_d;
        frame_q    <= frame_d;
      end
    end
  end

  assign frame_cube_flat = frame_q;
  assign frame_valid     = valid_q;

`ifdef FRAME_GEN_OVERRUN_CNT_EN
  logic [7:0] overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= 8'h00;
    end else if (tick && valid_q && !frame_ready && (overrun_q != 8'hFF)) begin
      overrun_q <= overrun_q + 8'h01;
    end
  end

  assign overrun_cnt = overrun_q;
`endif

endmodule

// File: tb/tb_anim_frame_gen.sv
// Directed bench for anim_frame_gen with CUBE_N=4, CLK_DIV=2 (base tick period 4 cycles).
module tb_anim_frame_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  display_speed = 4'd0;
  logic [1:0]  mode = 2'd0;
  logic        frame_ready = 1'b1;
  logic [63:0] frame_cube_flat;
  logic        frame_valid;
`ifdef FRAME_GEN_OVERRUN_CNT_EN
  logic [7:0]  overrun_cnt;
`endif

  int tests = 0;
  int fails = 0;

  anim_frame_gen #(.CUBE_N(4), .CLK_DIV(2), .SPEED_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .display_speed   (display_speed),
    .mode            (mode),
    .frame_ready     (frame_ready),
    .frame_cube_flat (frame_cube_flat),
    .frame_valid     (frame_valid)
`ifdef FRAME_GEN_OVERRUN_CNT_EN
    ,
    .overrun_cnt     (overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] row_f(input int r);
    logic [63:0] f;
    for (int i = 0; i < 64; i++) f[i] = ((i / 4) == r);
    return f;
  endfunction

  function automatic logic [63:0] plane_f(input int l);
    logic [63:0] f;
    for (int i = 0; i < 64; i++) f[i] = ((i / 16) == l);
    return f;
  endfunction

  function automatic logic [63:0] col_f(input int x);
    logic [63:0] f;
    for (int i = 0; i < 64; i++) f[i] = ((i % 4) == x);
    return f;
  endfunction

  function automatic logic [63:0] sparkle_f(input logic [31:0] s);
    logic [63:0] f;
    for (int i = 0; i < 64; i++) f[i] = s[i % 32] & s[(i + 7) % 32];
    return f;
  endfunction

  // Reference LFSR written as explicit toggles of the polynomial's tap positions.
  function automatic logic [31:0] lfsr_model(input logic [31:0] s);
    logic        out;
    logic [31:0] n;
    out = s[0];
    n   = s >> 1;
    if (out) begin
      n[31] = ~n[31];
      n[21] = ~n[21];
      n[1]  = ~n[1];
      n[0]  = ~n[0];
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_frame(input string tag, input int exp_lat, input bit chk_frame,
                            input logic [63:0] exp_frame);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_valid && n < 200);
    check({tag, "_valid"}, 64'(frame_valid), 64'd1);
    if (exp_lat > 0) check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    if (chk_frame) check({tag, "_frame"}, frame_cube_flat, exp_frame);
  endtask

  int plane_seq [8] = '{0, 1, 2, 3, 2, 1, 0, 1};
  logic [31:0] lf;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_frame", frame_cube_flat, 64'd0);
    check("rst_valid", 64'(frame_valid), 64'd0);
`ifdef FRAME_GEN_OVERRUN_CNT_EN
    check("rst_overrun", 64'(overrun_cnt), 64'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Bouncing plane, entered via a mode switch so it starts at layer 0.
    mode = 2'd1;
    en   = 1'b1;
    for (int k = 0; k < 8; k++) wait_frame($sformatf("plane%0d", k), 4, 1'b1, plane_f(plane_seq[k]));

    // Row scan through the wrap 15 -> 0, then three more rows.
    mode = 2'd0;
    for (int k = 0; k < 20; k++) wait_frame($sformatf("row%0d", k), 4, 1'b1, row_f(k % 16));

    // Switch to column after row 3: restarts at x=0.
    mode = 2'd2;
    wait_frame("col_sw0", 4, 1'b1, col_f(0));
    wait_frame("col_sw1", 4, 1'b1, col_f(1));

    // Slow down to S=3: 16-cycle period.
    display_speed = 4'd3;
    wait_frame("s3_a", 16, 1'b1, col_f(2));
    wait_frame("s3_b", 16, 1'b1, col_f(3));

    // Drop S to 0 with speed_cnt=2: it runs up to 15, wraps, then 4 more div counts.
    repeat (2) @(negedge clk);
    display_speed = 4'd0;
    wait_frame("s0_wrap", 18, 1'b1, col_f(0));
    wait_frame("s0_next", 4, 1'b1, col_f(1));

    // Backpressure for three tick periods.
    @(negedge clk);
    check("hs_clear", 64'(frame_valid), 64'd0);
    frame_ready = 1'b0;
    repeat (6) @(negedge clk);
    check("bp_valid1", 64'(frame_valid), 64'd1);
    check("bp_frame1", frame_cube_flat, col_f(2));
    repeat (5) @(negedge clk);
    check("bp_valid2", 64'(frame_valid), 64'd1);
    check("bp_frame2", frame_cube_flat, col_f(2));
`ifdef FRAME_GEN_OVERRUN_CNT_EN
    check("bp_overrun", 64'(overrun_cnt), 64'd2);
`endif
    frame_ready = 1'b1;
    @(negedge clk);
    check("bp_release", 64'(frame_valid), 64'd0);
    wait_frame("bp_resume", 3, 1'b1, col_f(3));

    // Disable: valid drops, frame held, timing restarts from zero.
    en = 1'b0;
    @(negedge clk);
    check("dis_valid", 64'(frame_valid), 64'd0);
    check("dis_frame", frame_cube_flat, col_f(3));
    repeat (3) @(negedge clk);
    check("dis_hold", frame_cube_flat, col_f(3));
`ifdef FRAME_GEN_OVERRUN_CNT_EN
    check("dis_overrun", 64'(overrun_cnt), 64'd2);
`endif
    en = 1'b1;
    wait_frame("reen", 4, 1'b1, col_f(0));

    // Sparkle, then asynchronous reset while a frame is pending.
    mode = 2'd3;
    wait_frame("spk_pre", 4, 1'b0, 64'd0);
    frame_ready = 1'b0;
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_frame", frame_cube_flat, 64'd0);
    check("arst_valid", 64'(frame_valid), 64'd0);
`ifdef FRAME_GEN_OVERRUN_CNT_EN
    check("arst_overrun", 64'(overrun_cnt), 64'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    frame_ready = 1'b1;
    lf = 32'hD650_8003;
    wait_frame("spk0", 4, 1'b1, sparkle_f(lf));
    lf = lfsr_model(lf);
    wait_frame("spk1", 4, 1'b1, sparkle_f(lf));
    lf = lfsr_model(lf);
    wait_frame("spk2", 4, 1'b1, sparkle_f(lf));

`ifdef FRAME_GEN_OVERRUN_CNT_EN
    frame_ready = 1'b0;
    repeat (1100) @(negedge clk);
    check("ovr_sat", 64'(overrun_cnt), 64'hFF);
    check("ovr_frame", frame_cube_flat, sparkle_f(lf));
    frame_ready = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
